// File: rtl/paddle_motion_ctrl.sv
// Paddle position controller: tick-gated motion with an acceleration ramp
// and an auto-track mode that follows target_y without overshooting it.
module paddle_motion_ctrl #(
    parameter int CW        = 13,
    parameter int FIELD_H   = 1920,
    parameter int SPEED_MIN = 4,
    parameter int SPEED_MAX = 32,
    parameter int ACCEL     = 4,
    parameter int DEADBAND  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          mode,
    input  logic          move_up,
    input  logic          move_down,
    input  logic [CW-1:0] target_y,
    input  logic [CW-1:0] size,
    input  logic [CW-1:0] init_x,
    input  logic [CW-1:0] init_y,
    output logic [CW-1:0] x_out,
    output logic [CW-1:0] y_out,
    output logic [CW-1:0] speed_out,
    output logic          at_top,
    output logic          at_bottom,
    output logic          moving
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RAMP   = 2'd1;
    localparam logic [1:0] CRUISE = 2'd2;

    localparam logic [CW:0]   FH_W   = (CW+1)'(FIELD_H);
    localparam logic [CW:0]   ACC_W  = (CW+1)'(ACCEL);
    localparam logic [CW:0]   DB_W   = (CW+1)'(DEADBAND);
    localparam logic [CW-1:0] SMIN_W = CW'(SPEED_MIN);
    localparam logic [CW-1:0] SMAX_W = CW'(SPEED_MAX);

    // Result is always within [lo, hi] and hi < 2**CW, so the top bit drops.
    function automatic logic [CW-1:0] clamp(input logic [CW:0] v,
                                             input logic [CW:0] lo,
                                             input logic [CW:0] hi);
        logic [CW:0] r;
        if (v < lo)
            r = lo;
        else if (v > hi)
            r = hi;
        else
            r = v;
        return r[CW-1:0];
    endfunction

    logic [1:0]    state_q, state_n;
    logic          dir_q, dir_n;
    logic [CW-1:0] speed_q, speed_n;
    logic [CW-1:0] step_q, step;
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q, y_d;

    logic [CW:0]        size_w, hi_w, y_w, step_w, y_move, abs_err, ramp_sum;
    logic signed [CW:0] err;
    logic               cmd_valid, cmd_down;

    assign size_w  = {1'b0, size};
    assign hi_w    = FH_W - size_w;
    assign y_w     = {1'b0, y_q};
    assign err     = $signed({1'b0, target_y}) - $signed(y_w);
    assign abs_err = err[CW] ? (CW+1)'(-err) : (CW+1)'(err);

    always_comb begin
        if (mode) begin
            cmd_valid = abs_err > DB_W;
            cmd_down  = ~err[CW];
        end else begin
            cmd_valid = move_up ^ move_down;
            cmd_down  = move_down;
        end
    end

    assign ramp_sum = {1'b0, speed_q} + ACC_W;

    always_comb begin
        state_n = state_q;
        dir_n   = dir_q;
        speed_n = speed_q;
        if (!cmd_valid) begin
            state_n = IDLE;
            speed_n = '0;
        end else if ((state_q != RAMP && state_q != CRUISE) || cmd_down != dir_q) begin
            state_n = RAMP;
            speed_n = SMIN_W;
            dir_n   = cmd_down;
        end else if (state_q == RAMP) begin
            if (ramp_sum >= {1'b0, SMAX_W}) begin
                state_n = CRUISE;
                speed_n = SMAX_W;
            end else begin
                speed_n = ramp_sum[CW-1:0];
            end
        end else begin
            speed_n = SMAX_W;
        end
    end

    // Auto mode trims the step to the remaining distance so target_y is not overshot.
    always_comb begin
        if (mode && abs_err < {1'b0, speed_n})
            step = abs_err[CW-1:0];
        else
            step = speed_n;
    end

    assign step_w = {1'b0, step};

    always_comb begin
        if (!cmd_valid)
            y_move = y_w;
        else if (cmd_down)
            y_move = (y_w + step_w > hi_w) ? hi_w : y_w + step_w;
        else
            y_move = (y_w < size_w + step_w) ? size_w : y_w - step_w;
        y_d = clamp(y_move, size_w, hi_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= init_x;
            y_q     <= clamp({1'b0, init_y}, size_w, hi_w);
            state_q <= IDLE;
            dir_q   <= 1'b0;
            speed_q <= '0;
            step_q  <= '0;
        end else if (tick) begin
            y_q     <= y_d;
            state_q <= state_n;
            dir_q   <= dir_n;
            speed_q <= speed_n;
            step_q  <= step;
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign speed_out = step_q;
    assign at_top    = (y_q == size);
    assign at_bottom = (y_w == hi_w);
    assign moving    = (state_q != IDLE);

endmodule
